// File: rtl/weight_seq_pkg.sv
// Shared constants and helpers for the weight/input lane sequencers.
// Mode m means each chunk is replicated 2^m times across 2^m beats.
package weight_seq_pkg;

    localparam logic [1:0] MODE_X1 = 2'd0;
    localparam logic [1:0] MODE_X2 = 2'd1;
    localparam logic [1:0] MODE_X4 = 2'd2;
    localparam logic [1:0] MODE_X8 = 2'd3;

    localparam int unsigned DEFAULT_CHUNK_W = 8;

    // A word of 2^log2_chunks chunks cannot be replicated more than 2^log2_chunks times.
    function automatic logic [1:0] clamp_mode(input logic [1:0] m, input int unsigned log2_chunks);
        if (32'(m) > log2_chunks) begin
            return log2_chunks[1:0];
        end
        return m;
    endfunction

endpackage

// File: rtl/weight_lane_sequencer_if.sv
// Word-in / beat-out handshake bundle of the lane sequencer.
// The slave modport is the sequencer side; master is the buffer plus consumer side.
interface weight_lane_sequencer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BEAT_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sorted_data;
    logic [BEAT_W-1:0] out_beat;
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, sorted_data, out_beat, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, sorted_data, out_beat, out_last
    );
endinterface

// File: rtl/chunk_replicator.sv
// Combinational beat builder: beat k of a word with every chunk replicated 2^m times.
// Output chunk j takes source chunk k*S + j/R, where R = 2^m and S = NUM_CHUNKS/R.
module chunk_replicator
    import weight_seq_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CHUNK_W    = DEFAULT_CHUNK_W,
    parameter int unsigned NUM_CHUNKS = 4
) (
    input  logic [DATA_W-1:0]             word,
    input  logic [1:0]                    m,
    input  logic [$clog2(NUM_CHUNKS)-1:0] k,
    output logic [DATA_W-1:0]             beat
);
    localparam int unsigned LOG2_CHUNKS = $clog2(NUM_CHUNKS);

    logic [1:0]             mc;
    logic [LOG2_CHUNKS-1:0] src;

    assign mc = clamp_mode(m, LOG2_CHUNKS);

    always_comb begin
        beat = '0;
        src  = '0;
        for (int j = 0; j < NUM_CHUNKS; j++) begin
            // k*S is k shifted by log2(S); j/R is j shifted by m.
            src = LOG2_CHUNKS'((32'(k) << (LOG2_CHUNKS - 32'(mc))) + (32'(j) >> mc));
            beat[j*CHUNK_W +: CHUNK_W] = word[32'(src)*CHUNK_W +: CHUNK_W];
        end
    end
endmodule

// File: rtl/weight_lane_sequencer.sv
// Holds one weight-buffer word and emits it as 2^mode replicated beats.
// A new word is accepted on the final beat's handshake, so words stream with no bubble.
module weight_lane_sequencer
    import weight_seq_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CHUNK_W    = DEFAULT_CHUNK_W,
    parameter int unsigned NUM_CHUNKS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [1:0]              mode,
    weight_lane_sequencer_if.slave  bus
);
    localparam int unsigned LOG2_CHUNKS = $clog2(NUM_CHUNKS);

    logic [DATA_W-1:0]      hold_q;
    logic [1:0]             mode_q;
    logic [LOG2_CHUNKS-1:0] beat_q;
    logic                   valid_q;

    logic [LOG2_CHUNKS-1:0] last_beat;
    logic                   is_last;
    logic                   accept;
    logic                   advance;
    logic [DATA_W-1:0]      beat_data;

    chunk_replicator #(
        .DATA_W     (DATA_W),
        .CHUNK_W    (CHUNK_W),
        .NUM_CHUNKS (NUM_CHUNKS)
    ) u_replicator (
        .word (hold_q),
        .m    (mode_q),
        .k    (beat_q),
        .beat (beat_data)
    );

    always_comb begin
        last_beat    = LOG2_CHUNKS'((32'd1 << mode_q) - 32'd1);
        is_last      = valid_q && (beat_q == last_beat);
        // Flush and reset both refuse the word so nothing slips in behind a drop.
        bus.in_ready = reset && !flush && (!valid_q || (bus.out_ready && is_last));
        accept       = bus.in_valid && bus.in_ready;
        advance      = valid_q && bus.out_ready;

        bus.out_valid   = valid_q;
        bus.sorted_data = valid_q ? beat_data : '0;
        bus.out_beat    = valid_q ? beat_q : '0;
        bus.out_last    = is_last;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_q  <= '0;
            mode_q  <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            beat_q  <= '0;
            valid_q <= 1'b0;
        end else if (accept) begin
            hold_q  <= bus.in_data;
            mode_q  <= clamp_mode(mode, LOG2_CHUNKS);
            beat_q  <= '0;
            valid_q <= 1'b1;
        end else if (advance) begin
            if (is_last) begin
                beat_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                beat_q <= beat_q + LOG2_CHUNKS'(1);
            end
        end
    end
endmodule

// File: tb/tb_weight_lane_sequencer.sv
// Directed bench for weight_lane_sequencer: a per-cycle vector table plus a flush sequence.
module tb_weight_lane_sequencer;
    import weight_seq_pkg::*;

    typedef struct {
        logic        rst;
        logic        fl;
        logic [1:0]  m;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_dat;
        logic [1:0]  e_beat;
        logic        e_last;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [1:0] mode;

    int total = 0;
    int bad   = 0;

    vec_t vecs[$];

    weight_lane_sequencer_if #(.DATA_W(32), .BEAT_W(2)) bus ();

    weight_lane_sequencer #(
        .DATA_W     (32),
        .CHUNK_W    (8),
        .NUM_CHUNKS (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .mode  (mode),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic [1:0] m, input logic iv,
                         input logic [31:0] d, input logic ordy);
        reset        = rst;
        flush        = fl;
        mode         = m;
        bus.in_valid = iv;
        bus.in_data  = d;
        bus.out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, MODE_X1, 1'b0, 32'h0, 1'b1);
        tick();

        // reset held with a word offered
        vecs.push_back('{1'b0, 1'b0, MODE_X1, 1'b1, 32'hDDCCBBAA, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, MODE_X1, 1'b1, 32'hDDCCBBAA, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0});
        // passthrough, back-to-back
        vecs.push_back('{1'b1, 1'b0, MODE_X1, 1'b1, 32'hDDCCBBAA, 1'b1, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, MODE_X1, 1'b1, 32'h11223344, 1'b1, 1'b1, 1'b1, 32'hDDCCBBAA, 2'd0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, MODE_X1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h11223344, 2'd0, 1'b1});
        // x2
        vecs.push_back('{1'b1, 1'b0, MODE_X2, 1'b1, 32'hDDCCBBAA, 1'b1, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, MODE_X2, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hBBBBAAAA, 2'd0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, MODE_X2, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hDDDDCCCC, 2'd1, 1'b1});
        // x4 with a stall, mode changed mid-word, a word offered while busy
        vecs.push_back('{1'b1, 1'b0, MODE_X4, 1'b1, 32'hDDCCBBAA, 1'b1, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, MODE_X1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hAAAAAAAA, 2'd0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, MODE_X1, 1'b1, 32'h55555555, 1'b0, 1'b0, 1'b1, 32'hBBBBBBBB, 2'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, MODE_X1, 1'b1, 32'h55555555, 1'b1, 1'b0, 1'b1, 32'hBBBBBBBB, 2'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, MODE_X1, 1'b1, 32'h55555555, 1'b1, 1'b0, 1'b1, 32'hCCCCCCCC, 2'd2, 1'b0});
        // last beat overlaps accept of an m=3 (clamped) word
        vecs.push_back('{1'b1, 1'b0, MODE_X8, 1'b1, 32'hDDCCBBAA, 1'b1, 1'b1, 1'b1, 32'hDDDDDDDD, 2'd3, 1'b1});
        vecs.push_back('{1'b1, 1'b0, MODE_X8, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hAAAAAAAA, 2'd0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, MODE_X8, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hBBBBBBBB, 2'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, MODE_X8, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hCCCCCCCC, 2'd2, 1'b0});
        vecs.push_back('{1'b1, 1'b0, MODE_X8, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hDDDDDDDD, 2'd3, 1'b1});
        vecs.push_back('{1'b1, 1'b0, MODE_X8, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0});

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].m, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            #1;
            check($sformatf("row%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ir));
            check($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            check($sformatf("row%0d sorted_data", i), bus.sorted_data, vecs[i].e_dat);
            check($sformatf("row%0d out_beat", i), 32'(bus.out_beat), 32'(vecs[i].e_beat));
            check($sformatf("row%0d out_last", i), 32'(bus.out_last), 32'(vecs[i].e_last));
            tick();
        end

        // flush during beat1 of an x4 word while a new word is offered
        drive(1'b1, 1'b0, MODE_X4, 1'b1, 32'h44332211, 1'b1);
        #1;
        check("flush accept ready", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b1, 1'b0, MODE_X4, 1'b0, 32'h0, 1'b1);
        #1;
        check("flush beat0 data", bus.sorted_data, 32'h11111111);
        tick();
        drive(1'b1, 1'b1, MODE_X1, 1'b1, 32'h99887766, 1'b1);
        #1;
        check("flush beat1 data", bus.sorted_data, 32'h22222222);
        check("flush beat1 index", 32'(bus.out_beat), 32'd1);
        check("flush forces ready low", 32'(bus.in_ready), 32'd0);
        tick();
        drive(1'b1, 1'b0, MODE_X4, 1'b0, 32'h0, 1'b1);
        #1;
        check("after flush out_valid", 32'(bus.out_valid), 32'd0);
        check("after flush data", bus.sorted_data, 32'h0);
        check("after flush ready", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b1, 1'b0, MODE_X4, 1'b1, 32'hDDCCBBAA, 1'b1);
        tick();
        drive(1'b1, 1'b0, MODE_X4, 1'b0, 32'h0, 1'b1);
        #1;
        check("post-flush valid", 32'(bus.out_valid), 32'd1);
        check("post-flush beat index", 32'(bus.out_beat), 32'd0);
        check("post-flush data", bus.sorted_data, 32'hAAAAAAAA);
        tick();
        #1;
        check("post-flush beat1 data", bus.sorted_data, 32'hBBBBBBBB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/weight_lane_sequencer.md
Name: weight_lane_sequencer

Overview:
Parametrised, registered successor to the weight-side buffer sorter. It accepts one DATA_W-bit word from the weight buffer per handshake and emits it over 2^mode output beats. Each beat carries a slice of the word with every CHUNK_W-bit chunk replicated 2^mode times, so the output is always DATA_W wide. The beat counter is internal; it is not driven by an external state input. Sits between the weight buffer read port and the fusion-unit array weight inputs.

Parameters:
DATA_W, 32, buffer word and output width; must equal CHUNK_W * NUM_CHUNKS.
CHUNK_W, 8, atomic chunk width that is replicated.
NUM_CHUNKS, 4, chunks per word; must be a power of two and at least 2.
LOG2_CHUNKS, $clog2(NUM_CHUNKS), derived, not overridable.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-low reset (reset==0 resets on the next rising clk).
flush  in  1  synchronous drop of the held word, active-high.
mode  in  2  replication exponent m. 0 = passthrough (1 beat), 1 = x2 (2 beats), 2 = x4 (4 beats), and so on. Values above LOG2_CHUNKS are clamped to LOG2_CHUNKS.
in_valid  in  1  buffer word valid.
in_ready  out  1  block can accept a word this cycle.
in_data  in  DATA_W  buffer word.
out_valid  out  1  sorted_data valid.
out_ready  in  1  consumer accepts the beat.
sorted_data  out  DATA_W  replicated beat.
out_beat  out  LOG2_CHUNKS  index of the current beat within the word.
out_last  out  1  current beat is the final beat of the word.

Behaviour:
- Reset (reset==0 at posedge):
  - held word, captured mode, beat counter and out_valid all go to 0.
  - sorted_data, out_beat and out_last read 0 while out_valid==0.
  - Reset overrides flush and any handshake in the same cycle.
- Accept occurs when in_valid && in_ready:
  - in_data and clamped mode are captured into hold registers.
  - The beat counter is set to 0 and out_valid is set to 1 on the next cycle.
  - Latency from accept to first valid beat is 1 cycle.
- in_ready = !out_valid || (out_ready && out_last).
  - This gives back-to-back words with no bubble.
  - A passthrough word (m=0) therefore sustains 1 word/cycle.
- Beat advance occurs when out_valid && out_ready:
  - If not last: counter increments.
  - If last: counter returns to 0, and out_valid stays 1 only if a new word is accepted in the same cycle; otherwise it drops to 0.
- Beat k data rule, with R = 2^m and S = NUM_CHUNKS/R:
  - output chunk j (j=0 is the LSB chunk) = held chunk (k*S + j/R), using integer division.
  - out_last = (k == R-1).
  - m=0 gives sorted_data = held word.
- The mode input is sampled only at accept. Changing mode mid-word does not affect the held word.
- Stalls: while out_valid && !out_ready, sorted_data, out_beat and out_last are held stable.
- flush=1 (with reset=1):
  - out_valid goes to 0 and the counter goes to 0 next cycle.
  - Any accept in the same cycle is discarded, and in_ready is forced to 0 that cycle.
- sorted_data is driven from the hold registers through combinational replication only. It is never a function of in_data in the same cycle.

Decomposition:
- Shared package weight_seq_pkg holds:
  - mode constants MODE_X1=0, MODE_X2=1, MODE_X4=2, MODE_X8=3;
  - the clamp function;
  - default CHUNK_W.
- One combinational sub-module chunk_replicator (parameters DATA_W, CHUNK_W, NUM_CHUNKS). Inputs are word, m and k; output is the beat. It is reusable by the input-side sequencer.
- The top level contains the hold registers, counter and handshake.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, sorted_data=0, in_ready=0. Release reset -> in_ready=1.
- m=0, words 0xDDCCBBAA then 0x11223344 back-to-back, out_ready=1 -> consecutive beats 0xDDCCBBAA, 0x11223344, out_last=1 on each, in_ready constantly 1.
- m=1, word 0xDDCCBBAA -> beat0 0xBBBBAAAA (out_beat=0, out_last=0), beat1 0xDDDDCCCC (out_last=1). in_ready=0 during beat0.
- m=2, word 0xDDCCBBAA, out_ready toggled 1,0,1,1,1 -> beats 0xAAAAAAAA, 0xBBBBBBBB (held across the stall), 0xCCCCCCCC, 0xDDDDDDDD. Mode changed to 0 mid-word has no effect.
- m=3 (clamped to 2 for NUM_CHUNKS=4) -> identical output to the m=2 case.
- Flush asserted during beat1 of an m=2 word, with in_valid=1 in the same cycle -> out_valid=0 next cycle, incoming word not captured. The next accept starts at beat0.
